test_iterator: RTL and testbench
================================

Name: test_iterator

Overview:
- Producer side of the sample-test interface. Accepts one bounding-boxed triangle at a time from the bbox stage.
- Walks every subsample position inside the box, one per cycle.
- Drives triangle, color, sample location and a valid flag into the sample-test stage.
- Stalls the upstream stage with an active-low halt while a box is being iterated.

Parameters:
SIGFIG, 24, bits in color and position
RADIX, 10, fraction bits in position
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
tri_R13S  in  [VERTS][AXIS]xSIGFIG signed  triangle from bbox stage
color_R13U  in  [COLORS]xSIGFIG unsigned  triangle color
box_R13S  in  [2][2]xSIGFIG signed  box [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y; pre-snapped to subsample grid
validTri_R13H  in  1  box/triangle valid
ss_w_lg2_R13S  in  4  log2 subsample steps per pixel, legal 0..3
halt_RnnnnnL  out  1  low = upstream must hold its outputs
tri_R14S  out  [VERTS][AXIS]xSIGFIG signed  held triangle
color_R14U  out  [COLORS]xSIGFIG unsigned  held color
sample_R14S  out  [2]xSIGFIG signed  current sample (x,y)
validSamp_R14H  out  1  sample_R14S is valid

Behaviour:
- Reset (rst low, asynchronous):
  - state=WAIT, halt_RnnnnnL=1, validSamp_R14H=0.
  - sample_R14S, tri_R14S, color_R14U, held box and held step all 0.
- Step: step = 1 << (RADIX - ss_w_lg2_R13S). Latched at accept, held for the whole box.
- FSM: two states, WAIT and TEST. halt_RnnnnnL = (state==WAIT), decoded from the state register.
- WAIT:
  - If validTri_R13H=1, accept on that edge:
    - latch tri, color, box and step;
    - sample_R14S <= box lower-left;
    - validSamp_R14H <= 1;
    - state <= TEST.
  - Otherwise validSamp_R14H <= 0.
- TEST, each edge:
  - nx = x + step.
  - If nx <= ur.x: x <= nx.
  - Else x <= ll.x and y <= y + step.
  - If nx > ur.x and y + step > ur.y, the box is finished: validSamp_R14H <= 0, state <= WAIT, sample_R14S holds.
  - validTri_R13H is ignored in TEST; upstream holds its outputs because halt is low.
- Latency and throughput:
  - First sample is visible the cycle after accept.
  - One sample per cycle, nx*ny consecutive valid cycles, where nx = (ur.x-ll.x)/step+1 and ny likewise.
- Back-to-back triangles: exactly one bubble cycle (validSamp_R14H=0) between the last sample of one box and the first sample of the next.
- Arithmetic:
  - Next-x and next-y are computed in SIGFIG+1 signed bits; comparisons are signed.
  - No wrap at the coordinate extremes.
- Boundaries:
  - ll==ur emits exactly one sample.
  - A box with ur<ll on either axis emits exactly one sample at ll; no fault is raised.
- Reset mid-iteration: validSamp_R14H drops immediately (asynchronous), halt_RnnnnnL returns to 1 and the partial box is discarded.
- Held outputs: tri_R14S and color_R14U are constant for all samples of a box.

Optional Feature:
- Macro: TEST_ITER_SERPENTINE_EN.
- Defined: boustrophedon scan.
  - Even rows (row 0 = ll.y) run left to right; odd rows run right to left.
  - At a row end, x stays at the edge column and y advances.
  - Termination rule and sample count are unchanged.
- Undefined: plain left-to-right raster for every row.

Decomposition:
- rast_pkg: iter_state_t enum {WAIT, TEST}, constant MAX_SS_W_LG2=3, and a packed sample_t of two SIGFIG signed fields.
- Sub-module sample_stepper: combinational next-sample logic.
  - Inputs: current sample, box, step, row parity.
  - Outputs: next sample, row_wrap, box_done.
  - The FSM and all registers stay in test_iterator.

Test Plan:
1. ss_w_lg2=0, box (0,0)-(2048,1024), validTri one cycle -> six consecutive samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024); halt low for 6 cycles; validSamp low on the 7th.
2. ss_w_lg2=2, box (0,0)-(256,256) -> step 256; samples (0,0),(256,0),(0,256),(256,256).
3. Box (512,512)-(512,512) -> exactly one valid cycle at (512,512); halt low for exactly 1 cycle.
4. Negative box (-1024,-1024)-(0,-1024), validTri held high across two triangles -> samples (-1024,-1024),(0,-1024), one bubble, then the second triangle's first sample; tri/color outputs switch only at the second accept.
5. rst pulsed low on the third sample of test 1 -> validSamp_R14H=0 and halt_RnnnnnL=1 with no clock edge; the next validTri restarts at ll.
6. With TEST_ITER_SERPENTINE_EN, test 1 box -> (0,0),(1024,0),(2048,0),(2048,1024),(1024,1024),(0,1024).

Source files
------------

// File: rtl/rast_pkg.sv
// Shared types and constants for the subsample test iterator.
package rast_pkg;

    localparam int unsigned SIGFIG       = 24;
    localparam int unsigned RADIX        = 10;
    localparam int unsigned VERTS        = 3;
    localparam int unsigned AXIS         = 3;
    localparam int unsigned COLORS       = 3;
    localparam int unsigned MAX_SS_W_LG2 = 3;

    typedef enum logic {
        WAIT = 1'b0,
        TEST = 1'b1
    } iter_state_t;

    // x sits in the low half so that [0]=x, [1]=y
    typedef struct packed {
        logic signed [SIGFIG-1:0] y;
        logic signed [SIGFIG-1:0] x;
    } sample_t;

    // ll in the low half so that [0]=lower-left, [1]=upper-right
    typedef struct packed {
        sample_t ur;
        sample_t ll;
    } box_t;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]           color_t;

    // Subsample step in fixed point; out-of-range log2 values clamp to the finest grid
    function automatic logic [SIGFIG-1:0] step_from_lg2(input logic [3:0] lg2);
        logic [3:0] eff;
        eff = (lg2 > 4'(MAX_SS_W_LG2)) ? 4'(MAX_SS_W_LG2) : lg2;
        return SIGFIG'(1) << (4'(RADIX) - eff);
    endfunction

endpackage

// File: rtl/test_iterator_if.sv
// Bbox-stage input and sample-test-stage output bundle of the test iterator.
interface test_iterator_if;
    import rast_pkg::*;

    tri_t        tri_R13S;
    color_t      color_R13U;
    box_t        box_R13S;
    logic        validTri_R13H;
    logic [3:0]  ss_w_lg2_R13S;

    logic        halt_RnnnnnL;
    tri_t        tri_R14S;
    color_t      color_R14U;
    sample_t     sample_R14S;
    logic        validSamp_R14H;

    // Iterator view: consumes boxes, produces samples
    modport master (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H, ss_w_lg2_R13S,
        output halt_RnnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );

    // Environment view: feeds boxes, observes samples
    modport slave (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H, ss_w_lg2_R13S,
        input  halt_RnnnnnL, tri_R14S, color_R14U, sample_R14S, validSamp_R14H
    );
endinterface

// File: rtl/sample_stepper.sv
// Combinational next-sample logic for the box walk.
// Build option: TEST_ITER_SERPENTINE_EN selects a boustrophedon scan.
module sample_stepper
    import rast_pkg::*;
(
    input  sample_t           cur,
    input  box_t              box,
    input  logic [SIGFIG-1:0] step,
    input  logic              row_odd,
    output sample_t           nxt,
    output logic              row_wrap,
    output logic              box_done
);

    localparam int unsigned EW = SIGFIG + 1;

    logic signed [EW-1:0] x_e, y_e, st_e, llx_e, lly_e, urx_e, ury_e;
    logic signed [EW-1:0] x_fwd, y_nxt;
    logic                 degenerate;

    // One extra bit of headroom so stepping past the extremes cannot wrap
    assign x_e   = {cur.x[SIGFIG-1], cur.x};
    assign y_e   = {cur.y[SIGFIG-1], cur.y};
    assign st_e  = {1'b0, step};
    assign llx_e = {box.ll.x[SIGFIG-1], box.ll.x};
    assign lly_e = {box.ll.y[SIGFIG-1], box.ll.y};
    assign urx_e = {box.ur.x[SIGFIG-1], box.ur.x};
    assign ury_e = {box.ur.y[SIGFIG-1], box.ur.y};
    assign x_fwd = x_e + st_e;
    assign y_nxt = y_e + st_e;

    // An inverted box on either axis yields only the lower-left sample
    assign degenerate = (urx_e < llx_e) || (ury_e < lly_e);

`ifdef TEST_ITER_SERPENTINE_EN
    logic signed [EW-1:0] x_bwd;
    assign x_bwd = x_e - st_e;

    // Even rows walk right, odd rows walk left; the edge column is reused on a row change
    always_comb begin
        nxt      = cur;
        row_wrap = 1'b0;
        if (row_odd) begin
            row_wrap = (x_bwd < llx_e);
            if (!row_wrap) nxt.x = x_bwd[SIGFIG-1:0];
        end else begin
            row_wrap = (x_fwd > urx_e);
            if (!row_wrap) nxt.x = x_fwd[SIGFIG-1:0];
        end
        if (row_wrap) nxt.y = y_nxt[SIGFIG-1:0];
        box_done = degenerate || (row_wrap && (y_nxt > ury_e));
    end
`else
    logic unused_row_odd;
    assign unused_row_odd = row_odd;

    // Raster walk: every row runs left to right and restarts at ll.x
    always_comb begin
        nxt      = cur;
        row_wrap = (x_fwd > urx_e);
        if (row_wrap) begin
            nxt.x = box.ll.x;
            nxt.y = y_nxt[SIGFIG-1:0];
        end else begin
            nxt.x = x_fwd[SIGFIG-1:0];
        end
        box_done = degenerate || (row_wrap && (y_nxt > ury_e));
    end
`endif

endmodule

// File: rtl/test_iterator.sv
// Walks every subsample of a bounding box, one per cycle, stalling upstream meanwhile.
// Build option: TEST_ITER_SERPENTINE_EN (serpentine scan order, see sample_stepper).
module test_iterator
    import rast_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    test_iterator_if.master bus
);

    iter_state_t       state, state_nxt;
    sample_t           sample_q, sample_nxt;
    box_t              box_q;
    logic [SIGFIG-1:0] step_q;
    tri_t              tri_q;
    color_t            color_q;
    logic              valid_q;
    logic              row_odd_q;
    logic              row_wrap, box_done;
    logic              accept, advance;

    sample_stepper u_stepper (
        .cur      (sample_q),
        .box      (box_q),
        .step     (step_q),
        .row_odd  (row_odd_q),
        .nxt      (sample_nxt),
        .row_wrap (row_wrap),
        .box_done (box_done)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT;
        else      state <= state_nxt;
    end

    // Next-state and datapath controls
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            WAIT: begin
                if (bus.validTri_R13H) begin
                    accept    = 1'b1;
                    state_nxt = TEST;
                end
            end
            TEST: begin
                if (box_done) state_nxt = WAIT;
                else          advance   = 1'b1;
            end
            default: state_nxt = WAIT;
        endcase
    end

    // Latch the triangle at accept, then step the sample once per cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sample_q  <= '0;
            box_q     <= '0;
            step_q    <= '0;
            tri_q     <= '0;
            color_q   <= '0;
            valid_q   <= 1'b0;
            row_odd_q <= 1'b0;
        end else begin
            valid_q <= accept || advance;
            if (accept) begin
                tri_q     <= bus.tri_R13S;
                color_q   <= bus.color_R13U;
                box_q     <= bus.box_R13S;
                step_q    <= step_from_lg2(bus.ss_w_lg2_R13S);
                sample_q  <= bus.box_R13S.ll;
                row_odd_q <= 1'b0;
            end else if (advance) begin
                sample_q <= sample_nxt;
                if (row_wrap) row_odd_q <= ~row_odd_q;
            end
        end
    end

    assign bus.halt_RnnnnnL   = (state == WAIT);
    assign bus.tri_R14S       = tri_q;
    assign bus.color_R14U     = color_q;
    assign bus.sample_R14S    = sample_q;
    assign bus.validSamp_R14H = valid_q;

endmodule

// File: tb/tb_test_iterator.sv
// Self-checking bench for test_iterator: directed plan plus random boxes against a scan-order model.
module tb_test_iterator;
    import rast_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    sample_t exp_q[$];

    test_iterator_if bus ();

    test_iterator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic sample_t mk(input int x, input int y);
        sample_t s;
        s.x = SIGFIG'(x);
        s.y = SIGFIG'(y);
        return s;
    endfunction

    // Expected scan order computed from box extents as rows x columns
    function automatic void model(input sample_t ll, input sample_t ur, input int ss);
        int step, lx, ly, ux, uy, ncol, nrow, cc;
        exp_q.delete();
        step = 1 << (RADIX - ss);
        lx = int'(ll.x); ly = int'(ll.y);
        ux = int'(ur.x); uy = int'(ur.y);
        if (ux < lx || uy < ly) begin
            exp_q.push_back(ll);
            return;
        end
        ncol = (ux - lx) / step + 1;
        nrow = (uy - ly) / step + 1;
        for (int r = 0; r < nrow; r++) begin
            for (int c = 0; c < ncol; c++) begin
`ifdef TEST_ITER_SERPENTINE_EN
                cc = (r % 2 == 1) ? (ncol - 1 - c) : c;
`else
                cc = c;
`endif
                exp_q.push_back(mk(lx + cc * step, ly + r * step));
            end
        end
    endfunction

    function automatic tri_t rnd_tri();
        return tri_t'({$urandom(), $urandom(), $urandom(), $urandom(),
                       $urandom(), $urandom(), $urandom()});
    endfunction

    function automatic color_t rnd_color();
        return color_t'({$urandom(), $urandom(), $urandom()});
    endfunction

    task automatic drive(input sample_t ll, input sample_t ur, input int ss,
                         input tri_t t, input color_t c);
        bus.box_R13S.ll   = ll;
        bus.box_R13S.ur   = ur;
        bus.ss_w_lg2_R13S = 4'(ss);
        bus.tri_R13S      = t;
        bus.color_R13U    = c;
        bus.validTri_R13H = 1'b1;
    endtask

    // Accept one box and check every sample, then the trailing bubble
    task automatic run_box(input string tag, input sample_t ll, input sample_t ur, input int ss,
                           input tri_t t, input color_t c, input bit keep_valid);
        model(ll, ur, ss);
        check({tag, " halt_idle"}, bus.halt_RnnnnnL, 1);
        drive(ll, ur, ss, t, c);
        tick();
        if (keep_valid) begin
            bus.tri_R13S   = rnd_tri();
            bus.color_R13U = rnd_color();
            bus.box_R13S   = {mk(0, 0), mk(0, 0)};
        end else begin
            bus.validTri_R13H = 1'b0;
        end
        foreach (exp_q[i]) begin
            check($sformatf("%s valid[%0d]", tag, i), bus.validSamp_R14H, 1);
            check($sformatf("%s sample[%0d]", tag, i), bus.sample_R14S, exp_q[i]);
            check($sformatf("%s halt[%0d]", tag, i), bus.halt_RnnnnnL, 0);
            check($sformatf("%s tri[%0d]", tag, i), bus.tri_R14S, t);
            check($sformatf("%s color[%0d]", tag, i), bus.color_R14U, c);
            tick();
        end
        check({tag, " valid_end"}, bus.validSamp_R14H, 0);
        check({tag, " halt_end"}, bus.halt_RnnnnnL, 1);
        check({tag, " sample_hold"}, bus.sample_R14S, exp_q[exp_q.size()-1]);
        check({tag, " tri_hold"}, bus.tri_R14S, t);
    endtask

    initial begin
        tri_t    t;
        color_t  c;
        int      ss, step, lx, ly, nx, ny, ux, uy;

        bus.tri_R13S      = '0;
        bus.color_R13U    = '0;
        bus.box_R13S      = '0;
        bus.validTri_R13H = 1'b0;
        bus.ss_w_lg2_R13S = '0;

        #2;
        check("rst halt", bus.halt_RnnnnnL, 1);
        check("rst valid", bus.validSamp_R14H, 0);
        check("rst sample", bus.sample_R14S, 0);
        check("rst tri", bus.tri_R14S, 0);
        check("rst color", bus.color_R14U, 0);
        #10;
        rst = 1'b1;
        tick();
        check("idle valid", bus.validSamp_R14H, 0);

        // Raster over a 3x2 box at full-pixel step
        run_box("t1", mk(0, 0), mk(2048, 1024), 0, rnd_tri(), rnd_color(), 1'b0);
        tick();
        // Quarter-pixel step
        run_box("t2", mk(0, 0), mk(256, 256), 2, rnd_tri(), rnd_color(), 1'b0);
        // Single-point box
        run_box("t3", mk(512, 512), mk(512, 512), 1, rnd_tri(), rnd_color(), 1'b0);
        // Inverted boxes: one sample at ll
        run_box("t3x", mk(1024, 0), mk(0, 2048), 0, rnd_tri(), rnd_color(), 1'b0);
        run_box("t3y", mk(0, 1024), mk(2048, 0), 0, rnd_tri(), rnd_color(), 1'b0);

        // Back-to-back with validTri held high: exactly one bubble
        t = rnd_tri();
        c = rnd_color();
        run_box("t4a", mk(-1024, -1024), mk(0, -1024), 0, t, c, 1'b1);
        run_box("t4b", mk(-2048, 512), mk(-1536, 1024), 1, rnd_tri(), rnd_color(), 1'b0);

        // Asynchronous reset on the third sample discards the box
        model(mk(0, 0), mk(2048, 1024), 0);
        drive(mk(0, 0), mk(2048, 1024), 0, rnd_tri(), rnd_color());
        tick();
        bus.validTri_R13H = 1'b0;
        tick();
        tick();
        check("t5 third sample", bus.sample_R14S, exp_q[2]);
        rst = 1'b0;
        #1;
        check("t5 async valid", bus.validSamp_R14H, 0);
        check("t5 async halt", bus.halt_RnnnnnL, 1);
        check("t5 async sample", bus.sample_R14S, 0);
        #1;
        rst = 1'b1;
        tick();
        run_box("t5r", mk(0, 0), mk(2048, 1024), 0, rnd_tri(), rnd_color(), 1'b0);

        // Random aligned boxes, some inverted, some back-to-back
        for (int k = 0; k < 10; k++) begin
            ss   = int'($urandom_range(0, 3));
            step = 1 << (RADIX - ss);
            lx   = (int'($urandom_range(0, 8)) - 4) * step;
            ly   = (int'($urandom_range(0, 8)) - 4) * step;
            nx   = int'($urandom_range(1, 4));
            ny   = int'($urandom_range(1, 3));
            ux   = lx + (nx - 1) * step;
            uy   = ly + (ny - 1) * step;
            if ($urandom_range(0, 5) == 0) ux = lx - step;
            if ($urandom_range(0, 5) == 0) uy = ly - step;
            run_box($sformatf("rnd%0d", k), mk(lx, ly), mk(ux, uy), ss,
                    rnd_tri(), rnd_color(), 1'($urandom_range(0, 1)));
        end

        bus.validTri_R13H = 1'b0;
        tick();
        tick();
        check("final valid", bus.validSamp_R14H, 0);
        check("final halt", bus.halt_RnnnnnL, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
